// File: rtl/lsu_cpx_ldret_q_if.sv
// Bundle of the CPX load-return, PCX issue and fill-stage signals of the LMQ return queue.
// The slave modport is the queue's view; the master modport is the view of whatever drives it.
interface lsu_cpx_ldret_q_if #(
  parameter int NTHR   = 4,
  parameter int TID_W  = 2,
  parameter int DATA_W = 128
);
  logic              ld_pcx_issue_vld;
  logic [TID_W-1:0]  ld_pcx_issue_tid;
  logic              cpx_vld;
  logic [3:0]        cpx_rtntyp;
  logic [TID_W-1:0]  cpx_tid;
  logic [1:0]        cpx_err;
  logic [DATA_W-1:0] cpx_data;
  logic              fill_vld;
  logic [TID_W-1:0]  fill_tid;
  logic [1:0]        fill_err;
  logic [DATA_W-1:0] fill_data;
  logic              fill_ack;
  logic [NTHR-1:0]   ld_done;
  logic [NTHR-1:0]   ld_pend;
  logic              ldq_afull;
  logic              err_unexp;
  logic              err_ovfl;

  modport slave (
    input  ld_pcx_issue_vld, ld_pcx_issue_tid,
    input  cpx_vld, cpx_rtntyp, cpx_tid, cpx_err, cpx_data,
    input  fill_ack,
    output fill_vld, fill_tid, fill_err, fill_data,
    output ld_done, ld_pend, ldq_afull, err_unexp, err_ovfl
  );

  modport master (
    output ld_pcx_issue_vld, ld_pcx_issue_tid,
    output cpx_vld, cpx_rtntyp, cpx_tid, cpx_err, cpx_data,
    output fill_ack,
    input  fill_vld, fill_tid, fill_err, fill_data,
    input  ld_done, ld_pend, ldq_afull, err_unexp, err_ovfl
  );
endinterface

// File: rtl/lsu_cpx_ldret_q.sv
// Load-return queue: qualifies CPX load returns against per-thread pending flags,
// buffers accepted returns in a small FIFO and releases LMQ entries as the fill stage consumes them.
module lsu_cpx_ldret_q #(
  parameter int          NTHR   = 4,
  parameter int          TID_W  = 2,
  parameter int          DATA_W = 128,
  parameter int          DEPTH  = 4,
  parameter logic [3:0]  LD_RTN = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  lsu_cpx_ldret_q_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = TID_W + 2 + DATA_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NTHR-1:0]  pend_q, pend_d;
  logic [NTHR-1:0]  done_q, done_d;
  logic             afull_q;
  logic             unexp_q, unexp_d;
  logic             ovfl_q, ovfl_d;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] head;
  logic [TID_W-1:0] head_tid;

  logic ret, pend_hit, fill_vld, pop, full_eff, push;

  assign ret      = bus.cpx_vld & (bus.cpx_rtntyp == LD_RTN);
  assign pend_hit = pend_q[bus.cpx_tid];
  assign fill_vld = (count_q != '0);
  assign pop      = fill_vld & bus.fill_ack;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign full_eff = (count_q == CNT_W'(DEPTH)) & ~pop;
  assign push     = ret & pend_hit & ~full_eff;
  assign head     = mem_q[rd_ptr_q];
  assign head_tid = head[ENT_W-1 -: TID_W];

  // New issue has priority over the clear from an accepted return on the same thread.
  generate
    for (genvar gi = 0; gi < NTHR; gi++) begin : g_thr
      assign pend_d[gi] = (bus.ld_pcx_issue_vld & (bus.ld_pcx_issue_tid == TID_W'(gi)))
                        | (pend_q[gi] & ~(push & (bus.cpx_tid == TID_W'(gi))));
      assign done_d[gi] = pop & (head_tid == TID_W'(gi));
    end
  endgenerate

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push & ~pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop & ~push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unexp_d = unexp_q | (ret & ~pend_hit);
    ovfl_d  = ovfl_q | (ret & pend_hit & full_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      done_q   <= '0;
      afull_q  <= 1'b0;
      unexp_q  <= 1'b0;
      ovfl_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      afull_q  <= (count_d >= CNT_W'(DEPTH - 1));
      unexp_q  <= unexp_d;
      ovfl_q   <= ovfl_d;
    end
  end

  // Storage is left unreset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cpx_tid, bus.cpx_err, bus.cpx_data};
    end
  end

  assign bus.fill_vld  = fill_vld;
  assign bus.fill_tid  = fill_vld ? head_tid : '0;
  assign bus.fill_err  = fill_vld ? head[DATA_W +: 2] : 2'b00;
  assign bus.fill_data = fill_vld ? head[DATA_W-1:0] : '0;
  assign bus.ld_done   = done_q;
  assign bus.ld_pend   = pend_q;
  assign bus.ldq_afull = afull_q;
  assign bus.err_unexp = unexp_q;
  assign bus.err_ovfl  = ovfl_q;

endmodule

// File: tb/tb_lsu_cpx_ldret_q.sv
// Bench for lsu_cpx_ldret_q: a directed vector table, multi-cycle corner sequences on
// DEPTH=4 and DEPTH=2 instances, then randomized traffic against a queue-based model.
module tb_lsu_cpx_ldret_q;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  lsu_cpx_ldret_q_if #(.NTHR(4), .TID_W(2), .DATA_W(DW)) b4 ();
  lsu_cpx_ldret_q_if #(.NTHR(4), .TID_W(2), .DATA_W(DW)) b2 ();

  lsu_cpx_ldret_q #(.NTHR(4), .TID_W(2), .DATA_W(DW), .DEPTH(4), .LD_RTN(4'h0)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  lsu_cpx_ldret_q #(.NTHR(4), .TID_W(2), .DATA_W(DW), .DEPTH(2), .LD_RTN(4'h0)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  typedef struct {
    logic       iv;
    logic [1:0] it;
    logic       cv;
    logic [3:0] typ;
    logic [1:0] ct;
    logic [1:0] ce;
    logic [7:0] cd;
    logic       ack;
    logic       e_vld;
    logic [1:0] e_tid;
    logic [1:0] e_err;
    logic [7:0] e_dat;
    logic [3:0] e_done;
    logic [3:0] e_pend;
    logic       e_afull;
    logic       e_unexp;
  } vec_t;

  typedef struct {
    logic [1:0]    tid;
    logic [1:0]    err;
    logic [DW-1:0] data;
  } ent_t;

  vec_t tbl [13];

  // Reference model state (DEPTH=4 instance)
  ent_t       mq [$];
  logic [3:0] m_pend;
  logic [3:0] m_done;
  logic       m_unexp;
  logic       m_ovfl;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b4.ld_pcx_issue_vld = 1'b0; b4.ld_pcx_issue_tid = '0;
    b4.cpx_vld = 1'b0; b4.cpx_rtntyp = 4'h0; b4.cpx_tid = '0; b4.cpx_err = '0;
    b4.cpx_data = '0; b4.fill_ack = 1'b0;
    b2.ld_pcx_issue_vld = 1'b0; b2.ld_pcx_issue_tid = '0;
    b2.cpx_vld = 1'b0; b2.cpx_rtntyp = 4'h0; b2.cpx_tid = '0; b2.cpx_err = '0;
    b2.cpx_data = '0; b2.fill_ack = 1'b0;
  endtask

  // One clocked cycle on instance w (4 or 2): optional issue, optional load return, ack.
  task automatic cyc(input int w, input logic iv, input logic [1:0] it, input logic cv,
                     input logic [1:0] ct, input logic [7:0] cd, input logic ack);
    idle();
    if (w == 4) begin
      b4.ld_pcx_issue_vld = iv; b4.ld_pcx_issue_tid = it;
      b4.cpx_vld = cv; b4.cpx_tid = ct; b4.cpx_data = {16{cd}}; b4.fill_ack = ack;
    end else begin
      b2.ld_pcx_issue_vld = iv; b2.ld_pcx_issue_tid = it;
      b2.cpx_vld = cv; b2.cpx_tid = ct; b2.cpx_data = {16{cd}}; b2.fill_ack = ack;
    end
    tick();
    idle();
  endtask

  task automatic model_step();
    logic ret, hit, pop, full_eff, push;
    if (rst) begin
      mq.delete();
      m_pend = '0; m_done = '0; m_unexp = 1'b0; m_ovfl = 1'b0;
      return;
    end
    ret      = b4.cpx_vld && (b4.cpx_rtntyp == 4'h0);
    hit      = m_pend[b4.cpx_tid];
    pop      = (mq.size() != 0) && b4.fill_ack;
    full_eff = (mq.size() == 4) && !pop;
    push     = ret && hit && !full_eff;
    if (ret && !hit) m_unexp = 1'b1;
    if (ret && hit && full_eff) m_ovfl = 1'b1;
    m_done = pop ? (4'b0001 << mq[0].tid) : 4'b0000;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back('{tid: b4.cpx_tid, err: b4.cpx_err, data: b4.cpx_data});
      m_pend[b4.cpx_tid] = 1'b0;
    end
    if (b4.ld_pcx_issue_vld) m_pend[b4.ld_pcx_issue_tid] = 1'b1;
  endtask

  task automatic model_check();
    logic ev;
    ev = (mq.size() != 0);
    chk("rnd.fill_vld", DW'(b4.fill_vld), DW'(ev));
    chk("rnd.fill_tid", DW'(b4.fill_tid), ev ? DW'(mq[0].tid) : '0);
    chk("rnd.fill_err", DW'(b4.fill_err), ev ? DW'(mq[0].err) : '0);
    chk("rnd.fill_data", b4.fill_data, ev ? mq[0].data : '0);
    chk("rnd.ld_done", DW'(b4.ld_done), DW'(m_done));
    chk("rnd.ld_pend", DW'(b4.ld_pend), DW'(m_pend));
    chk("rnd.ldq_afull", DW'(b4.ldq_afull), DW'(mq.size() >= 3));
    chk("rnd.err_unexp", DW'(b4.err_unexp), DW'(m_unexp));
    chk("rnd.err_ovfl", DW'(b4.err_ovfl), DW'(m_ovfl));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] order [4];
    logic [3:0] afull_exp;
    //            iv it cv typ ct ce cd     ack | vld tid err dat    done     pend     af ux
    tbl[0]  = '{1, 2, 0, 4'h0, 0, 0, 8'h00, 0,   0,  0,  0,  8'h00, 4'b0000, 4'b0100, 0, 0};
    tbl[1]  = '{0, 0, 1, 4'h0, 2, 0, 8'hA5, 0,   1,  2,  0,  8'hA5, 4'b0000, 4'b0000, 0, 0};
    tbl[2]  = '{0, 0, 0, 4'h0, 0, 0, 8'h00, 1,   0,  0,  0,  8'h00, 4'b0100, 4'b0000, 0, 0};
    tbl[3]  = '{0, 0, 0, 4'h0, 0, 0, 8'h00, 0,   0,  0,  0,  8'h00, 4'b0000, 4'b0000, 0, 0};
    tbl[4]  = '{0, 0, 1, 4'h0, 1, 0, 8'h5A, 0,   0,  0,  0,  8'h00, 4'b0000, 4'b0000, 0, 1};
    tbl[5]  = '{1, 3, 1, 4'h3, 3, 0, 8'h66, 0,   0,  0,  0,  8'h00, 4'b0000, 4'b1000, 0, 1};
    tbl[6]  = '{0, 0, 1, 4'h5, 3, 0, 8'h66, 0,   0,  0,  0,  8'h00, 4'b0000, 4'b1000, 0, 1};
    tbl[7]  = '{1, 0, 0, 4'h0, 0, 0, 8'h00, 0,   0,  0,  0,  8'h00, 4'b0000, 4'b1001, 0, 1};
    tbl[8]  = '{1, 0, 1, 4'h0, 0, 2, 8'h3C, 0,   1,  0,  2,  8'h3C, 4'b0000, 4'b1001, 0, 1};
    tbl[9]  = '{0, 0, 1, 4'h0, 3, 1, 8'h77, 1,   1,  3,  1,  8'h77, 4'b0001, 4'b0001, 0, 1};
    tbl[10] = '{0, 0, 1, 4'h0, 0, 0, 8'h11, 1,   1,  0,  0,  8'h11, 4'b1000, 4'b0000, 0, 1};
    tbl[11] = '{0, 0, 0, 4'h0, 0, 0, 8'h00, 1,   0,  0,  0,  8'h00, 4'b0001, 4'b0000, 0, 1};
    tbl[12] = '{0, 0, 0, 4'h0, 0, 0, 8'h00, 1,   0,  0,  0,  8'h00, 4'b0000, 4'b0000, 0, 1};

    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst.fill_vld", DW'(b4.fill_vld), '0);
    chk("rst.ld_pend", DW'(b4.ld_pend), '0);
    chk("rst.ld_done", DW'(b4.ld_done), '0);
    chk("rst.ldq_afull", DW'(b4.ldq_afull), '0);
    chk("rst.err_unexp", DW'(b4.err_unexp), '0);
    chk("rst.err_ovfl", DW'(b4.err_ovfl), '0);
    chk("rst.fill_data", b4.fill_data, '0);
    rst = 1'b0;

    // Directed vector table on the DEPTH=4 instance
    for (int i = 0; i < 13; i++) begin
      idle();
      b4.ld_pcx_issue_vld = tbl[i].iv; b4.ld_pcx_issue_tid = tbl[i].it;
      b4.cpx_vld = tbl[i].cv; b4.cpx_rtntyp = tbl[i].typ; b4.cpx_tid = tbl[i].ct;
      b4.cpx_err = tbl[i].ce; b4.cpx_data = {16{tbl[i].cd}}; b4.fill_ack = tbl[i].ack;
      tick();
      $display("vec %0d: fill_vld=%0b tid=%0d done=%b pend=%b unexp=%0b",
               i, b4.fill_vld, b4.fill_tid, b4.ld_done, b4.ld_pend, b4.err_unexp);
      chk("tbl.fill_vld", DW'(b4.fill_vld), DW'(tbl[i].e_vld));
      chk("tbl.fill_tid", DW'(b4.fill_tid), DW'(tbl[i].e_tid));
      chk("tbl.fill_err", DW'(b4.fill_err), DW'(tbl[i].e_err));
      chk("tbl.fill_data", b4.fill_data, {16{tbl[i].e_dat}});
      chk("tbl.ld_done", DW'(b4.ld_done), DW'(tbl[i].e_done));
      chk("tbl.ld_pend", DW'(b4.ld_pend), DW'(tbl[i].e_pend));
      chk("tbl.ldq_afull", DW'(b4.ldq_afull), DW'(tbl[i].e_afull));
      chk("tbl.err_unexp", DW'(b4.err_unexp), DW'(tbl[i].e_unexp));
    end
    idle();

    // Four returns out of issue order, no acks: afull after the third, pops in arrival order
    order[0] = 2'd3; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd2;
    afull_exp = 4'b1100;
    for (int t = 0; t < 4; t++) cyc(4, 1'b1, 2'(t), 1'b0, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(4, 1'b0, 2'd0, 1'b1, order[i], 8'h30 + 8'(order[i]), 1'b0);
      $display("seq3 ret tid=%0d afull=%0b", order[i], b4.ldq_afull);
      chk("seq3.afull_fill", DW'(b4.ldq_afull), DW'(afull_exp[i]));
    end
    afull_exp = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk("seq3.head_vld", DW'(b4.fill_vld), DW'(1));
      chk("seq3.head_tid", DW'(b4.fill_tid), DW'(order[i]));
      chk("seq3.head_data", b4.fill_data, {16{8'h30 + 8'(order[i])}});
      cyc(4, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1);
      $display("seq3 pop tid=%0d done=%b", order[i], b4.ld_done);
      chk("seq3.done", DW'(b4.ld_done), DW'(4'b0001 << order[i]));
      chk("seq3.afull_drain", DW'(b4.ldq_afull), DW'(afull_exp[i]));
    end
    chk("seq3.empty", DW'(b4.fill_vld), DW'(0));
    tick();
    chk("seq3.done_one_cycle", DW'(b4.ld_done), DW'(0));

    // Reset with three entries buffered and all threads pending
    for (int t = 0; t < 4; t++) cyc(4, 1'b1, 2'(t), 1'b0, 2'd0, 8'h00, 1'b0);
    for (int t = 0; t < 3; t++) cyc(4, 1'b0, 2'd0, 1'b1, 2'(t), 8'h40 + 8'(t), 1'b0);
    for (int t = 0; t < 3; t++) cyc(4, 1'b1, 2'(t), 1'b0, 2'd0, 8'h00, 1'b0);
    chk("seq6.pre_pend", DW'(b4.ld_pend), DW'(4'b1111));
    chk("seq6.pre_afull", DW'(b4.ldq_afull), DW'(1));
    chk("seq6.pre_vld", DW'(b4.fill_vld), DW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("seq6 reset: fill_vld=%0b pend=%b", b4.fill_vld, b4.ld_pend);
    chk("seq6.fill_vld", DW'(b4.fill_vld), DW'(0));
    chk("seq6.fill_data", b4.fill_data, '0);
    chk("seq6.ld_pend", DW'(b4.ld_pend), DW'(0));
    chk("seq6.afull", DW'(b4.ldq_afull), DW'(0));
    chk("seq6.unexp", DW'(b4.err_unexp), DW'(0));
    chk("seq6.ovfl", DW'(b4.err_ovfl), DW'(0));
    cyc(4, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0);
    cyc(4, 1'b0, 2'd0, 1'b1, 2'd1, 8'h99, 1'b0);
    chk("seq6.new_head_tid", DW'(b4.fill_tid), DW'(1));
    chk("seq6.new_head_data", b4.fill_data, {16{8'h99}});
    chk("seq6.new_afull", DW'(b4.ldq_afull), DW'(0));
    cyc(4, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("seq6.drained", DW'(b4.fill_vld), DW'(0));

    // DEPTH=2: third return while full is dropped
    for (int t = 0; t < 3; t++) cyc(2, 1'b1, 2'(t), 1'b0, 2'd0, 8'h00, 1'b0);
    cyc(2, 1'b0, 2'd0, 1'b1, 2'd0, 8'h50, 1'b0);
    chk("seq4a.afull", DW'(b2.ldq_afull), DW'(1));
    cyc(2, 1'b0, 2'd0, 1'b1, 2'd1, 8'h51, 1'b0);
    chk("seq4a.ovfl_before", DW'(b2.err_ovfl), DW'(0));
    cyc(2, 1'b0, 2'd0, 1'b1, 2'd2, 8'h52, 1'b0);
    $display("seq4a drop: ovfl=%0b pend=%b", b2.err_ovfl, b2.ld_pend);
    chk("seq4a.ovfl", DW'(b2.err_ovfl), DW'(1));
    chk("seq4a.pend", DW'(b2.ld_pend), DW'(4'b0100));
    chk("seq4a.head", DW'(b2.fill_tid), DW'(0));
    tick();
    chk("seq4a.ovfl_sticky", DW'(b2.err_ovfl), DW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // DEPTH=2: same fill, but the third return coincides with a pop
    for (int t = 0; t < 3; t++) cyc(2, 1'b1, 2'(t), 1'b0, 2'd0, 8'h00, 1'b0);
    cyc(2, 1'b0, 2'd0, 1'b1, 2'd0, 8'h60, 1'b0);
    cyc(2, 1'b0, 2'd0, 1'b1, 2'd1, 8'h61, 1'b0);
    cyc(2, 1'b0, 2'd0, 1'b1, 2'd2, 8'h62, 1'b1);
    $display("seq4b accept: ovfl=%0b pend=%b done=%b", b2.err_ovfl, b2.ld_pend, b2.ld_done);
    chk("seq4b.ovfl", DW'(b2.err_ovfl), DW'(0));
    chk("seq4b.pend", DW'(b2.ld_pend), DW'(0));
    chk("seq4b.done", DW'(b2.ld_done), DW'(4'b0001));
    chk("seq4b.head", DW'(b2.fill_tid), DW'(1));
    cyc(2, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("seq4b.head2_tid", DW'(b2.fill_tid), DW'(2));
    chk("seq4b.head2_data", b2.fill_data, {16{8'h62}});
    cyc(2, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("seq4b.empty", DW'(b2.fill_vld), DW'(0));
    chk("seq4b.done2", DW'(b2.ld_done), DW'(4'b0100));

    // Randomized traffic against the model, starting from reset
    idle();
    rst = 1'b1;
    model_step();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      idle();
      b4.ld_pcx_issue_vld = 1'($urandom % 2);
      b4.ld_pcx_issue_tid = 2'($urandom % 4);
      b4.cpx_vld          = ($urandom % 3) != 0;
      b4.cpx_rtntyp       = (($urandom % 6) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      b4.cpx_tid          = 2'($urandom % 4);
      b4.cpx_err          = 2'($urandom % 4);
      b4.cpx_data         = {$urandom, $urandom, $urandom, $urandom};
      b4.fill_ack         = ($urandom % 3) != 0;
      rst                 = (($urandom % 97) == 0);
      model_step();
      tick();
      model_check();
    end
    rst = 1'b0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
